// File: rtl/or1200_cl_dec_xor.sv
// Refill-side pad XOR: buffers encrypted line words, waits for the AES pads,
// then streams plaintext to the data cache in line order, one word per cycle.
module or1200_cl_dec_xor #(
  parameter int LINE_WORDS  = 8,
  parameter int DW          = 32,
  parameter int PAD_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          secure_exec,
  input  logic          refill_start,
  input  logic          enc_done,
  input  logic [127:0]  enc_pad_1,
  input  logic [127:0]  enc_pad_2,
  input  logic [DW-1:0] biu_dat_i,
  input  logic          biu_ack_i,
  output logic [DW-1:0] dec_dat_o,
  output logic          dec_ack_o,
  output logic          dec_busy,
  output logic          line_done,
  output logic          pad_err,
  output logic [1:0]    dbg_state
);

  localparam int IW = $clog2(LINE_WORDS);
  localparam int PW = $clog2(LINE_WORDS + 1);
  localparam int CW = $clog2(PAD_TIMEOUT);
  localparam logic [PW-1:0] LW      = PW'(LINE_WORDS);
  localparam logic [PW-1:0] LW_LAST = PW'(LINE_WORDS - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(PAD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_PAD = 2'd1, DRAIN = 2'd2} state_t;

  state_t          state;
  logic [DW-1:0]   buf_q [LINE_WORDS];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic [255:0]    pad_q;

  logic [255:0]    pad_eff;
  logic [7:0]      pad_base;
  logic [DW-1:0]   pad_word;
  logic [IW-1:0]   wr_idx, rd_idx;
  logic            wr_en, rd_en;

  // dec_ack_o is a pure valid strobe: the cache always accepts, so there is
  // no ready and each asserted cycle transfers exactly one word.
  assign dec_busy  = (state != IDLE);
  assign dbg_state = state;
  assign wr_idx    = wr_ptr[IW-1:0];
  assign rd_idx    = rd_ptr[IW-1:0];

  // On the enc_done edge the pads are not yet registered, so the first word
  // is XORed with the live pad inputs to save a cycle.
  assign pad_eff   = (state == WAIT_PAD) ? {enc_pad_1, enc_pad_2} : pad_q;
  assign pad_base  = 8'd255 - 8'({rd_idx, 5'b00000});
  assign pad_word  = pad_eff[pad_base -: DW];

  assign wr_en = (state != IDLE) && biu_ack_i && (wr_ptr < LW);
  assign rd_en = ((state == DRAIN) || (state == WAIT_PAD && enc_done)) && (rd_ptr < wr_ptr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      pad_q     <= '0;
      dec_dat_o <= '0;
      dec_ack_o <= 1'b0;
      line_done <= 1'b0;
      pad_err   <= 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) buf_q[i] <= '0;
    end else begin
      dec_ack_o <= 1'b0;
      line_done <= 1'b0;
      pad_err   <= 1'b0;

      if (wr_en) begin
        buf_q[wr_idx] <= biu_dat_i;
        wr_ptr        <= wr_ptr + 1'b1;
      end

      if (rd_en) begin
        dec_dat_o <= buf_q[rd_idx] ^ pad_word;
        dec_ack_o <= 1'b1;
        rd_ptr    <= rd_ptr + 1'b1;
      end

      case (state)
        IDLE: begin
          if (refill_start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            if (secure_exec) begin
              state <= WAIT_PAD;
            end else begin
              pad_q <= '0;
              state <= DRAIN;
            end
          end
        end
        WAIT_PAD: begin
          if (enc_done) begin
            pad_q <= {enc_pad_1, enc_pad_2};
            state <= DRAIN;
          end else if (cnt == TO_LAST) begin
            pad_err <= 1'b1;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (rd_en && rd_ptr == LW_LAST) begin
            line_done <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
